// File: rtl/l1_l2_req_arb_pkg.sv
// rtl/l1_l2_req_arb_pkg.sv - shared types and opcodes for the L1-to-L2 request arbiter
package l1_l2_req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_L1D = 1'b0,
    OWNER_L1I = 1'b1
  } arb_owner_t;

  localparam logic [3:0] MEM_LW = 4'd4;

endpackage

// File: rtl/l1_l2_req_arb_if.sv
// rtl/l1_l2_req_arb_if.sv - L1D/L1I request/response and L2 request bus bundle
interface l1_l2_req_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128,
  parameter int OP_W   = 4
);

  logic              l1d_req_valid;
  logic [ADDR_W-1:0] l1d_req_addr;
  logic [OP_W-1:0]   l1d_req_opcode;
  logic [DATA_W-1:0] l1d_req_store_data;
  logic              l1d_req_ack;
  logic              l1d_rsp_valid;

  logic              l1i_req_valid;
  logic [ADDR_W-1:0] l1i_req_addr;
  logic              l1i_req_ack;
  logic              l1i_rsp_valid;

  logic [DATA_W-1:0] l1_rsp_data;

  logic              l2_req_valid;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [OP_W-1:0]   l2_req_opcode;
  logic [DATA_W-1:0] l2_req_store_data;
  logic              l2_req_ready;
  logic              l2_rsp_valid;
  logic [DATA_W-1:0] l2_rsp_data;

  // Arbiter view.
  modport master (
    input  l1d_req_valid, l1d_req_addr, l1d_req_opcode, l1d_req_store_data,
    output l1d_req_ack, l1d_rsp_valid,
    input  l1i_req_valid, l1i_req_addr,
    output l1i_req_ack, l1i_rsp_valid,
    output l1_rsp_data,
    output l2_req_valid, l2_req_addr, l2_req_opcode, l2_req_store_data,
    input  l2_req_ready, l2_rsp_valid, l2_rsp_data
  );

  // Caches and L2 view.
  modport slave (
    output l1d_req_valid, l1d_req_addr, l1d_req_opcode, l1d_req_store_data,
    input  l1d_req_ack, l1d_rsp_valid,
    output l1i_req_valid, l1i_req_addr,
    input  l1i_req_ack, l1i_rsp_valid,
    input  l1_rsp_data,
    input  l2_req_valid, l2_req_addr, l2_req_opcode, l2_req_store_data,
    output l2_req_ready, l2_rsp_valid, l2_rsp_data
  );

endinterface

// File: rtl/l1_l2_req_arb_rr_pick2.sv
// rtl/l1_l2_req_arb_rr_pick2.sv - two-input round-robin picker (bit0 = L1D, bit1 = L1I)
module l1_l2_req_arb_rr_pick2
  import l1_l2_req_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == OWNER_L1I) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/l1_l2_req_arb.sv
// rtl/l1_l2_req_arb.sv - single-outstanding L1D/L1I to L2 request arbiter; optional ARB_PERF_COUNTERS_EN
module l1_l2_req_arb
  import l1_l2_req_arb_pkg::*;
#(
  parameter int              ADDR_W      = 64,
  parameter int              DATA_W      = 128,
  parameter int              OP_W        = 4,
  parameter logic [OP_W-1:0] L1I_FILL_OP = MEM_LW
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_l2_req_arb_if.master       bus,
  input  logic                  flush_active,
  output logic                  arb_idle
`ifdef ARB_PERF_COUNTERS_EN
  ,output logic [63:0]          l1d_grants
  ,output logic [63:0]          l1i_grants
  ,output logic [63:0]          conflict_cycles
`endif
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              l2_req_valid_q, l2_req_valid_d;
  logic              l1d_ack_q, l1d_ack_d;
  logic              l1i_ack_q, l1i_ack_d;
  logic              l1d_rsp_q, l1d_rsp_d;
  logic              l1i_rsp_q, l1i_rsp_d;
  logic              arb_idle_q, arb_idle_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              complete;

  assign req = {bus.l1i_req_valid, bus.l1d_req_valid};

  l1_l2_req_arb_rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign grant_en = (state_q == IDLE) && !flush_active && (gnt != 2'b00);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    opcode_d       = opcode_q;
    store_data_d   = store_data_q;
    rsp_data_d     = rsp_data_q;
    l2_req_valid_d = l2_req_valid_q;
    l1d_ack_d      = 1'b0;
    l1i_ack_d      = 1'b0;
    l1d_rsp_d      = 1'b0;
    l1i_rsp_d      = 1'b0;
    complete       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d        = ISSUE;
          l2_req_valid_d = 1'b1;
          if (gnt[0]) begin
            owner_d      = OWNER_L1D;
            last_grant_d = OWNER_L1D;
            addr_d       = bus.l1d_req_addr;
            opcode_d     = bus.l1d_req_opcode;
            store_data_d = bus.l1d_req_store_data;
            l1d_ack_d    = 1'b1;
          end else if (gnt[1]) begin
            owner_d      = OWNER_L1I;
            last_grant_d = OWNER_L1I;
            addr_d       = bus.l1i_req_addr;
            opcode_d     = L1I_FILL_OP;
            store_data_d = '0;
            l1i_ack_d    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.l2_req_ready) begin
          l2_req_valid_d = 1'b0;
          if (bus.l2_rsp_valid) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (bus.l2_rsp_valid) begin
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An L2 response that collapses onto the accept cycle finishes the same way as one in WAIT_RSP.
    if (complete) begin
      state_d    = IDLE;
      rsp_data_d = bus.l2_rsp_data;
      l1d_rsp_d  = (owner_q == OWNER_L1D);
      l1i_rsp_d  = (owner_q == OWNER_L1I);
    end

    arb_idle_d = (state_d == IDLE) && !l1d_rsp_d && !l1i_rsp_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_L1D;
      last_grant_q   <= OWNER_L1I;
      addr_q         <= '0;
      opcode_q       <= '0;
      store_data_q   <= '0;
      rsp_data_q     <= '0;
      l2_req_valid_q <= 1'b0;
      l1d_ack_q      <= 1'b0;
      l1i_ack_q      <= 1'b0;
      l1d_rsp_q      <= 1'b0;
      l1i_rsp_q      <= 1'b0;
      arb_idle_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      addr_q         <= addr_d;
      opcode_q       <= opcode_d;
      store_data_q   <= store_data_d;
      rsp_data_q     <= rsp_data_d;
      l2_req_valid_q <= l2_req_valid_d;
      l1d_ack_q      <= l1d_ack_d;
      l1i_ack_q      <= l1i_ack_d;
      l1d_rsp_q      <= l1d_rsp_d;
      l1i_rsp_q      <= l1i_rsp_d;
      arb_idle_q     <= arb_idle_d;
    end
  end

  assign bus.l1d_req_ack       = l1d_ack_q;
  assign bus.l1i_req_ack       = l1i_ack_q;
  assign bus.l1d_rsp_valid     = l1d_rsp_q;
  assign bus.l1i_rsp_valid     = l1i_rsp_q;
  assign bus.l1_rsp_data       = rsp_data_q;
  assign bus.l2_req_valid      = l2_req_valid_q;
  assign bus.l2_req_addr       = addr_q;
  assign bus.l2_req_opcode     = opcode_q;
  assign bus.l2_req_store_data = store_data_q;
  assign arb_idle              = arb_idle_q;

`ifdef ARB_PERF_COUNTERS_EN
  logic [63:0] l1d_grants_q, l1d_grants_d;
  logic [63:0] l1i_grants_q, l1i_grants_d;
  logic [63:0] conflict_q, conflict_d;
  logic        conflict;

  // Counts both true ties and cycles where a pending request cannot be served at all.
  always_comb begin
    conflict = ((state_q == IDLE) && (req == 2'b11)) ||
               ((req != 2'b00) && ((state_q != IDLE) || flush_active));
    l1d_grants_d = l1d_grants_q + {63'd0, grant_en & gnt[0]};
    l1i_grants_d = l1i_grants_q + {63'd0, grant_en & gnt[1]};
    conflict_d   = conflict_q + {63'd0, conflict};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1d_grants_q <= '0;
      l1i_grants_q <= '0;
      conflict_q   <= '0;
    end else begin
      l1d_grants_q <= l1d_grants_d;
      l1i_grants_q <= l1i_grants_d;
      conflict_q   <= conflict_d;
    end
  end

  assign l1d_grants      = l1d_grants_q;
  assign l1i_grants      = l1i_grants_q;
  assign conflict_cycles = conflict_q;
`endif

endmodule

// File: doc/l1_l2_req_arb.md
Name: l1_l2_req_arb

Overview:
- Arbitrates miss/writeback requests from the L1 data cache and L1 instruction cache onto the single L2 request port.
- Holds exactly one transaction outstanding at a time and routes the L2 response valid and line data back to the requester that owns it.
- Sits between the dcache/icache memory ports and the l2 cache inside the core_l1d_l1i-level integration.
- Blocks new grants while a cache flush sequence is active.

Parameters:
- ADDR_W, 64, request address width (matches `M_WIDTH).
- DATA_W, 128, cache-line data width for store and load data.
- OP_W, 4, memory opcode width.
- L1I_FILL_OP, 4'd4, opcode driven to L2 for every L1I request (line load).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- l1d_req_valid  in  1  L1D request pending; held high until l1d_req_ack
- l1d_req_addr  in  ADDR_W  L1D line address
- l1d_req_opcode  in  OP_W  L1D opcode (load/store/writeback)
- l1d_req_store_data  in  DATA_W  L1D writeback/store line
- l1d_req_ack  out  1  one-cycle grant pulse to L1D
- l1d_rsp_valid  out  1  one-cycle completion pulse to L1D
- l1i_req_valid  in  1  L1I fill request pending
- l1i_req_addr  in  ADDR_W  L1I line address
- l1i_req_ack  out  1  one-cycle grant pulse to L1I
- l1i_rsp_valid  out  1  one-cycle completion pulse to L1I
- l1_rsp_data  out  DATA_W  registered line data, valid with either rsp pulse
- flush_active  in  1  flush in progress; inhibits new grants
- l2_req_valid  out  1  request to L2
- l2_req_addr  out  ADDR_W  latched address
- l2_req_opcode  out  OP_W  latched opcode
- l2_req_store_data  out  DATA_W  latched store data
- l2_req_ready  in  1  L2 accepts request this cycle
- l2_rsp_valid  in  1  L2 completes the outstanding request
- l2_rsp_data  in  DATA_W  L2 line data
- arb_idle  out  1  high when state is IDLE and no response pulse is pending

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; all outputs 0; holding registers 0.
  - last_grant=L1I, so the first tie goes to L1D.
- States:
  - IDLE, when flush_active=0 and at least one valid is high:
    - Select winner: a single requester wins; if both are valid, the requester not equal to last_grant wins.
    - Latch addr/opcode/store_data (L1I uses L1I_FILL_OP, store_data 0).
    - Record owner; update last_grant; go to ISSUE.
    - Next cycle: pulse the winner's ack for exactly 1 cycle.
  - IDLE, flush_active=1: no grant; valids ignored and left pending.
  - ISSUE: l2_req_valid=1 with latched fields, stable until accepted.
    - l2_req_ready=1 and l2_rsp_valid=0 -> WAIT_RSP.
    - l2_req_ready=1 and l2_rsp_valid=1 in the same cycle -> complete directly (same as WAIT_RSP completion).
  - WAIT_RSP: on l2_rsp_valid, register l2_rsp_data into l1_rsp_data, go to IDLE.
    - Next cycle: pulse the owner's rsp_valid for 1 cycle.
- Response rules:
  - l2_rsp_valid outside ISSUE/WAIT_RSP is ignored.
  - l1_rsp_data holds its value until the next response.
- Latency and throughput:
  - Request valid at cycle 0 (IDLE) -> ack and l2_req_valid at cycle 1.
  - l2_rsp_valid at cycle N -> rsp_valid/data at cycle N+1.
  - A new grant is possible in the cycle of the rsp pulse (state is IDLE), so back-to-back throughput is one transaction per L2 round trip + 2 cycles.
- Every granted request receives exactly one rsp pulse, including stores and writebacks.
- flush_active rising during ISSUE/WAIT_RSP has no effect; the in-flight transaction completes, then grants are inhibited.
- Requesters must drop valid the cycle after ack. The arbiter never re-grants before completion, so a held valid cannot double-issue.
- Reset mid-transaction discards the transaction; no rsp pulse is produced.

Optional Feature:
- Macro: ARB_PERF_COUNTERS_EN.
- Defined: adds outputs l1d_grants, l1i_grants and conflict_cycles (64 bits each), all reset to 0.
  - Grant counters increment on each grant.
  - conflict_cycles increments each IDLE cycle where both valids are high, or any cycle where a valid is high but no grant is possible (non-IDLE state or flush_active).
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (uop.vh/machine.vh domain):
  - typedef arb_state_t {IDLE, ISSUE, WAIT_RSP}.
  - typedef arb_owner_t {OWNER_L1D, OWNER_L1I}.
  - constant MEM_LW used as the L1I_FILL_OP default.
- One natural sub-module: rr_pick2, a 2-input round-robin picker (valids + last_grant -> one-hot grant). Everything else is in the top.

Test Plan:
- L1D only, addr 0x1000, op 7: ack at cycle 1; l2_req_valid held 3 cycles until ready; l2_rsp_valid 4 cycles later -> l1d_rsp_valid 1 cycle later; l1i_rsp_valid never asserts.
- Both valid after reset: L1D granted first; L1I granted in the IDLE cycle after L1D completes; third simultaneous pair -> L1D again (alternation).
- flush_active=1 with both valid for 10 cycles: no ack, l2_req_valid=0, arb_idle=1; drop flush -> grant the next cycle.
- l2_req_ready and l2_rsp_valid in the same cycle for an L1I request with data 0xDEAD...: l1i_rsp_valid the next cycle, l1_rsp_data=0xDEAD...
- Reset asserted during WAIT_RSP: all outputs 0 immediately; a later l2_rsp_valid produces no rsp pulse.
- ARB_PERF_COUNTERS_EN: 5 simultaneous-request pairs -> l1d_grants=5, l1i_grants=5, conflict_cycles ≥ 5.
